data_cache: RTL
===============

Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache for the CPU core.
- Sits between the MEMORY pipeline stage and the backing data memory.
- Returns read hits in the same cycle.
- Asserts `stall` to freeze the pipeline while a miss fill or a write-through is outstanding against the backing memory.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; one word per line.
- SETS, 8, number of lines; power of two, at least 2.
- CNT_WIDTH, 16, width of the hit and miss counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- cpu_re  in  1  load request from the MEMORY stage.
- cpu_we  in  1  store request from the MEMORY stage.
- cpu_addr  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data; valid in any cycle with cpu_re=1 and stall=0.
- stall  out  1  freeze the pipeline; the request must be held stable while this is 1.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  backing-memory write enable.
- mem_addr  out  ADDRESS_WIDTH  word-aligned backing-memory address.
- mem_wdata  out  DATA_WIDTH  backing-memory write data.
- mem_ack  in  1  one-cycle completion pulse from the backing memory.
- mem_rdata  in  DATA_WIDTH  read data; valid with mem_ack.
- hit_cnt  out  CNT_WIDTH  count of read hits.
- miss_cnt  out  CNT_WIDTH  count of read misses.

Behaviour:
- Address split:
  - IDX = log2(SETS).
  - index = cpu_addr[IDX+1:2].
  - tag = cpu_addr[ADDRESS_WIDTH-1:IDX+2].
  - Per line storage: valid bit, tag, data word.
- hit = cpu_re & ~cpu_we & valid[index] & (tag == stored tag).
- If cpu_re and cpu_we are both 1, the access is treated as a store.
- Reset (rst=0 at a clk edge):
  - All valid bits cleared; state IDLE.
  - mem_req=0, mem_we=0, stall=0; hit_cnt and miss_cnt = 0.
  - Tag and data arrays are not reset.
  - Reset during RD_MISS or WR_THRU abandons the transaction: mem_req drops on the next cycle and no line is installed. A late mem_ack arriving in IDLE is ignored.
- FSM states: IDLE, RD_MISS, WR_THRU, RESP.
- IDLE:
  - Read hit: stall=0; cpu_rdata = line data, combinational; hit_cnt increments. Latency 0.
  - Read miss: stall=1, combinational, in the same cycle; next state RD_MISS; miss_cnt increments once.
  - Store: stall=1; next state WR_THRU.
  - No request: stall=0; cpu_rdata = 0.
- RD_MISS:
  - mem_req=1, mem_we=0, mem_addr = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00}; stall=1.
  - On mem_ack: install {valid=1, tag, mem_rdata} at index; capture mem_rdata into resp_q; next state RESP.
- WR_THRU:
  - mem_req=1, mem_we=1, mem_wdata = cpu_wdata; stall=1.
  - On mem_ack: if the line is valid with a matching tag, its data is replaced by cpu_wdata (update on hit). A miss does not allocate. Next state RESP.
- RESP:
  - stall=0; cpu_rdata = resp_q for a load; the request retires this cycle; next state IDLE.
  - Neither counter changes in RESP.
- Handshake: mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the mem_ack cycle inclusive. mem_req is 0 in IDLE and RESP. Arbitrary ack latency of 1 cycle or more is supported.
- Latencies:
  - Read miss: L + 1 stalled cycles, where L = cycles from mem_req to mem_ack.
  - Store: L + 1 stalled cycles.
- Counters: wrap modulo 2^CNT_WIDTH.
- Back-to-back requests: a request presented in the cycle after RESP is evaluated fresh in IDLE. A read of the just-stored address hits with the new data.

Decomposition:
- dcache_pkg:
  - State enum type (IDLE, RD_MISS, WR_THRU, RESP).
  - Functions or localparams deriving IDX and tag width from SETS and ADDRESS_WIDTH.
- Sub-module dcache_line_store:
  - Valid, tag and data arrays.
  - Asynchronous read port; one synchronous write port.
  - Synchronous active-low clear of the valid bits.
- data_cache holds the FSM, the counters, resp_q and the memory-side drive.

Test Plan:
- Cold read: after reset, cpu_re to 0x40; memory acks after 3 cycles with 0xDEADBEEF -> stall high for 4 cycles; mem_addr=0x40; cpu_rdata=0xDEADBEEF in RESP; miss_cnt=1.
- Hit: repeat the read of 0x40 -> stall=0, cpu_rdata=0xDEADBEEF in the same cycle, hit_cnt=1, mem_req stays 0.
- Conflict: read 0x60 (same index as 0x40 with SETS=8, different tag) -> miss and refill. A subsequent read of 0x40 misses again; miss_cnt=3.
- Store update: store 0x12345678 to 0x60 while it is cached -> mem_we=1, mem_wdata=0x12345678 held until ack. Next read of 0x60 hits with 0x12345678.
- No-allocate: store to 0x80 while uncached -> write-through issued; next read of 0x80 misses (miss_cnt increments).
- Reset mid-miss: drive rst=0 during RD_MISS before ack, then ack 1 cycle later -> mem_req=0, state IDLE, ack ignored. A read of that address misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRdMiss,
      StWrThru,
      StResp
   } dcache_state_e;

   function automatic int unsigned idx_width(input int unsigned sets);
      return $clog2(sets);
   endfunction

   // Word offset occupies the two low address bits.
   function automatic int unsigned tag_width(input int unsigned addr_width,
                                             input int unsigned sets);
      return addr_width - 2 - $clog2(sets);
   endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bus of the data cache, plus its hit/miss counters.
interface dcache_if #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned CNT_WIDTH     = 16
) ();
   import dcache_pkg::*;

   logic                     cpu_re;
   logic                     cpu_we;
   logic [ADDRESS_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0]    cpu_wdata;
   logic [DATA_WIDTH-1:0]    cpu_rdata;
   logic                     stall;

   logic                     mem_req;
   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]    mem_wdata;
   logic                     mem_ack;
   logic [DATA_WIDTH-1:0]    mem_rdata;

   logic [CNT_WIDTH-1:0]     hit_cnt;
   logic [CNT_WIDTH-1:0]     miss_cnt;

   modport slave (
      input  cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
      output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
   );

   modport master (
      output cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
      input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
   );

endinterface

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: asynchronous read, one synchronous write, clearable valid bits.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int unsigned SETS       = 8,
   parameter int unsigned TAG_WIDTH  = 27,
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned IDX       = idx_width(SETS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IDX-1:0]        rd_idx,
   output logic                  rd_valid,
   output logic [TAG_WIDTH-1:0]  rd_tag,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [IDX-1:0]        wr_idx,
   input  logic [TAG_WIDTH-1:0]  wr_tag,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   logic [SETS-1:0]       valid_q;
   logic [TAG_WIDTH-1:0]  tag_q  [SETS];
   logic [DATA_WIDTH-1:0] data_q [SETS];

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Tag and data carry no reset; a cleared valid bit masks stale contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between MEMORY stage and data memory.
module data_cache
   import dcache_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned SETS          = 8,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input logic     clk,
   input logic     rst,
   dcache_if.slave bus
);

   localparam int unsigned IDX       = idx_width(SETS);
   localparam int unsigned TAG_WIDTH = tag_width(ADDRESS_WIDTH, SETS);

   dcache_state_e state_q, state_d;
   logic [DATA_WIDTH-1:0] resp_q, resp_d;
   logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
   logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

   logic [IDX-1:0]        index;
   logic [TAG_WIDTH-1:0]  tag;
   logic                  line_valid;
   logic [TAG_WIDTH-1:0]  line_tag;
   logic [DATA_WIDTH-1:0] line_data;
   logic                  tag_match;
   logic                  is_load;
   logic                  is_store;

   logic                     wr_en;
   logic [DATA_WIDTH-1:0]    wr_data;
   logic                     stall;
   logic [DATA_WIDTH-1:0]    cpu_rdata;
   logic                     mem_req;
   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]    mem_wdata;
   logic [ADDRESS_WIDTH-1:0] word_addr;

   assign index     = bus.cpu_addr[IDX+1:2];
   assign tag       = bus.cpu_addr[ADDRESS_WIDTH-1:IDX+2];
   assign word_addr = bus.cpu_addr & ~ADDRESS_WIDTH'(3);
   assign tag_match = line_valid & (line_tag == tag);
   // A simultaneous load and store request is handled as a store.
   assign is_store  = bus.cpu_we;
   assign is_load   = bus.cpu_re & ~bus.cpu_we;

   dcache_line_store #(
      .SETS       (SETS),
      .TAG_WIDTH  (TAG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_line_store (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (index),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (wr_en),
      .wr_idx   (index),
      .wr_tag   (tag),
      .wr_data  (wr_data)
   );

   always_comb begin
      state_d    = state_q;
      resp_d     = resp_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      wr_en      = 1'b0;
      wr_data    = bus.mem_rdata;
      stall      = 1'b0;
      cpu_rdata  = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;

      unique case (state_q)
         StIdle: begin
            if (is_store) begin
               stall   = 1'b1;
               state_d = StWrThru;
            end else if (is_load) begin
               if (tag_match) begin
                  cpu_rdata = line_data;
                  hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
               end else begin
                  stall      = 1'b1;
                  miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                  state_d    = StRdMiss;
               end
            end
         end
         StRdMiss: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = word_addr;
            if (bus.mem_ack) begin
               wr_en   = 1'b1;
               wr_data = bus.mem_rdata;
               resp_d  = bus.mem_rdata;
               state_d = StResp;
            end
         end
         StWrThru: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = word_addr;
            mem_wdata = bus.cpu_wdata;
            if (bus.mem_ack) begin
               // Update only a resident line; store misses never allocate.
               wr_en   = tag_match;
               wr_data = bus.cpu_wdata;
               state_d = StResp;
            end
         end
         StResp: begin
            if (is_load) begin
               cpu_rdata = resp_q;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      resp_q <= resp_d;
   end

   assign bus.stall     = stall;
   assign bus.cpu_rdata = cpu_rdata;
   assign bus.mem_req   = mem_req;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.hit_cnt   = hit_cnt_q;
   assign bus.miss_cnt  = miss_cnt_q;

endmodule
